// File: rtl/csa_compressor_pipe.sv
// csa_compressor_pipe: pipelined N:2 carry-save compressor built from levels
// of 3:2 CSAs, one register stage per level, valid/ready flow control.
// Optional build macro CSA_FINAL_ADD_EN adds a registered final adder stage
// that produces out_sum = out_s1 + out_s2.

// Single 3:2 carry-save adder slice; the carry is pre-shifted and its MSB dropped.
module csa_3to2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  output logic [WIDTH-1:0] s_o,
  output logic [WIDTH-1:0] c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = ((a_i & b_i) | (a_i & c_i) | (b_i & c_i)) << 1;
endmodule

module csa_compressor_pipe #(
  parameter int WIDTH   = 32,
  parameter int NUM_OPS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_OPS*WIDTH-1:0]   in_ops,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_s1,
  output logic [WIDTH-1:0]           out_s2
`ifdef CSA_FINAL_ADD_EN
  ,
  output logic [WIDTH-1:0]           out_sum
`endif
);

  // Live vector count after lvl reduction levels.
  function automatic int vec_cnt(input int n, input int lvl);
    int c;
    c = n;
    for (int i = 0; i < lvl; i++) c = 2 * (c / 3) + c % 3;
    return c;
  endfunction

  // Number of 3:2 levels needed to reach two vectors.
  function automatic int num_levels(input int n);
    int c;
    int l;
    c = n;
    l = 0;
    for (int i = 0; i < 8; i++) begin
      if (c > 2) begin
        c = 2 * (c / 3) + c % 3;
        l++;
      end
    end
    return l;
  endfunction

  localparam int LVLS = num_levels(NUM_OPS);
`ifdef CSA_FINAL_ADD_EN
  localparam int FA = 1;
`else
  localparam int FA = 0;
`endif
  localparam int STAGES = LVLS + FA;

  if (NUM_OPS < 3 || NUM_OPS > 8) begin : g_bad_num_ops
    $error("csa_compressor_pipe: NUM_OPS must be in 3..8");
  end

  typedef logic [NUM_OPS-1:0][WIDTH-1:0] vecs_t;

  // stg[0] is the operand set at the input; stg[k] is the register of level k,
  // zero-padded above its live vector count.
  vecs_t               stg [LVLS:0];
  logic [STAGES:1]     vld_q;
  logic [STAGES:0]     vld_pipe;
  logic [STAGES+1:1]   rdy;
  logic [STAGES:1]     ld;

  assign vld_pipe = {vld_q, in_valid};

  // Ready chains combinationally from the output back toward the input.
  always_comb begin
    rdy = '0;
    rdy[STAGES+1] = out_ready;
    for (int k = STAGES; k >= 1; k--) rdy[k] = ~vld_q[k] | rdy[k+1];
  end

  assign ld        = vld_pipe[STAGES-1:0] & rdy[STAGES:1];
  assign in_ready  = rdy[1];
  assign out_valid = vld_q[STAGES];

  // A stage's valid follows its upstream whenever the stage can accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        if (rdy[k]) vld_q[k] <= vld_pipe[k-1];
      end
    end
  end

  assign stg[0] = in_ops;

  for (genvar k = 0; k < LVLS; k++) begin : g_lvl
    localparam int NIN  = vec_cnt(NUM_OPS, k);
    localparam int NOUT = vec_cnt(NUM_OPS, k + 1);
    localparam int NG   = NIN / 3;
    localparam int NR   = NIN % 3;

    logic [NOUT-1:0][WIDTH-1:0] dat_d;
    logic [NOUT-1:0][WIDTH-1:0] dat_q;

    // Groups of three go through a CSA: sum to even slot, carry to odd slot.
    for (genvar j = 0; j < NG; j++) begin : g_csa
      csa_3to2 #(.WIDTH(WIDTH)) u_csa (
        .a_i (stg[k][3*j]),
        .b_i (stg[k][3*j+1]),
        .c_i (stg[k][3*j+2]),
        .s_o (dat_d[2*j]),
        .c_o (dat_d[2*j+1])
      );
    end

    // Leftover vectors ride along unchanged behind the CSA outputs.
    for (genvar j = 0; j < NR; j++) begin : g_pass
      assign dat_d[2*NG+j] = stg[k][3*NG+j];
    end

    // Level register loads only on a transfer into this stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        dat_q <= '0;
      else if (ld[k+1])  dat_q <= dat_d;
    end

    assign stg[k+1] = {{((NUM_OPS - NOUT) * WIDTH){1'b0}}, dat_q};
  end

  // Padding slots of the stage arrays are never read by the reduction.
  logic unused_stg;
  always_comb begin
    unused_stg = 1'b0;
    for (int k = 0; k <= LVLS; k++) unused_stg = unused_stg ^ (^stg[k]);
  end

`ifdef CSA_FINAL_ADD_EN
  logic [WIDTH-1:0] s1_q, s2_q, sum_q, sum_d;

  assign sum_d = stg[LVLS][0] + stg[LVLS][1];

  // Final adder stage; s1/s2 are re-registered to stay aligned with the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      sum_q <= '0;
    end else if (ld[STAGES]) begin
      s1_q  <= stg[LVLS][0];
      s2_q  <= stg[LVLS][1];
      sum_q <= sum_d;
    end
  end

  assign out_s1  = s1_q;
  assign out_s2  = s2_q;
  assign out_sum = sum_q;
`else
  assign out_s1 = stg[LVLS][0];
  assign out_s2 = stg[LVLS][1];
`endif

endmodule

// File: tb/tb_csa_compressor_pipe.sv
// Scoreboard bench for csa_compressor_pipe: a 32-bit/4-operand instance and an
// 8-bit/7-operand instance share clock and reset. Accepted input sets push an
// expected modulo sum; output monitors pop and compare in order.
module tb_csa_compressor_pipe;
  localparam int AW = 32, AN = 4, BW = 8, BN = 7;
`ifdef CSA_FINAL_ADD_EN
  localparam int FA = 1;
`else
  localparam int FA = 0;
`endif
  localparam int LAT_A = 2 + FA;
  localparam int LAT_B = 4 + FA;

  typedef struct {
    logic [31:0] sum;
    int          cyc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic              a_iv, a_ir, a_ov, a_or;
  logic [AN*AW-1:0]  a_ops;
  logic [AW-1:0]     a_s1, a_s2;
  logic              b_iv, b_ir, b_ov, b_or;
  logic [BN*BW-1:0]  b_ops;
  logic [BW-1:0]     b_s1, b_s2;
`ifdef CSA_FINAL_ADD_EN
  logic [AW-1:0]     a_sum;
  logic [BW-1:0]     b_sum;
`endif

  csa_compressor_pipe #(.WIDTH(AW), .NUM_OPS(AN)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_ops(a_ops),
    .out_valid(a_ov), .out_ready(a_or), .out_s1(a_s1), .out_s2(a_s2)
`ifdef CSA_FINAL_ADD_EN
    , .out_sum(a_sum)
`endif
  );

  csa_compressor_pipe #(.WIDTH(BW), .NUM_OPS(BN)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_ops(b_ops),
    .out_valid(b_ov), .out_ready(b_or), .out_s1(b_s1), .out_s2(b_s2)
`ifdef CSA_FINAL_ADD_EN
    , .out_sum(b_sum)
`endif
  );

  exp_t        qa[$], qb[$];
  logic [31:0] a_exp, b_exp;
  bit          a_lat, b_lat;
  int          a_tot = 0, b_tot = 0, b_win = 0, b_first = 0, b_last = 0, b_waits = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] msum_a(input logic [AN*AW-1:0] ops);
    logic [AW-1:0] s = '0;
    for (int k = 0; k < AN; k++) s = s + ops[k*AW +: AW];
    return s;
  endfunction

  function automatic logic [31:0] msum_b(input logic [BN*BW-1:0] ops);
    logic [BW-1:0] s = '0;
    for (int k = 0; k < BN; k++) s = s + ops[k*BW +: BW];
    return {24'b0, s};
  endfunction

  // Input monitors: every accepted set enqueues its expected result.
  always @(negedge clk) begin
    if (rst_n && a_iv && a_ir) qa.push_back('{a_exp, cyc, a_lat});
    if (rst_n && b_iv && b_ir) qb.push_back('{b_exp, cyc, b_lat});
  end

  // Output monitor A: order, value, latency and stall stability.
  logic          a_hold = 1'b0;
  logic [AW-1:0] a_p1, a_p2;
  always @(negedge clk) begin
    if (rst_n && a_ov) begin
      if (a_hold) begin
        chk("a_stall_s1_stable", a_s1, a_p1);
        chk("a_stall_s2_stable", a_s2, a_p2);
      end
      if (a_or) begin
        logic [AW-1:0] t;
        exp_t e;
        a_hold = 1'b0;
        a_tot++;
        t = a_s1 + a_s2;
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_output: got s1+s2=%0h expected no output", t);
        end else begin
          e = qa.pop_front();
          chk("a_s1_plus_s2", t, e.sum);
`ifdef CSA_FINAL_ADD_EN
          chk("a_out_sum", a_sum, e.sum);
`endif
          if (e.lat) chk("a_latency", 32'(cyc - e.cyc), 32'(LAT_A));
        end
      end else begin
        a_hold = 1'b1; a_p1 = a_s1; a_p2 = a_s2;
      end
    end else a_hold = 1'b0;
  end

  // Output monitor B.
  always @(negedge clk) begin
    if (rst_n && b_ov && b_or) begin
      logic [BW-1:0] t;
      exp_t e;
      b_tot++;
      if (b_win == 0) b_first = cyc;
      b_win++;
      b_last = cyc;
      t = b_s1 + b_s2;
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_output: got s1+s2=%0h expected no output", t);
      end else begin
        e = qb.pop_front();
        chk("b_s1_plus_s2", {24'b0, t}, e.sum);
`ifdef CSA_FINAL_ADD_EN
        chk("b_out_sum", {24'b0, b_sum}, e.sum);
`endif
        if (e.lat) chk("b_latency", 32'(cyc - e.cyc), 32'(LAT_B));
      end
    end
  end

  task automatic send_a(input logic [AN*AW-1:0] ops, input logic [31:0] ex, input bit lat);
    int n = 0;
    a_ops = ops; a_exp = ex; a_lat = lat; a_iv = 1'b1;
    forever begin
      @(negedge clk);
      if (a_ir) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL a_send_timeout: in_ready low for %0d cycles, expected accept", n);
        break;
      end
    end
    @(posedge clk); #1;
    a_iv = 1'b0;
  endtask

  task automatic send_b(input logic [BN*BW-1:0] ops, input logic [31:0] ex, input bit lat);
    int n = 0;
    b_ops = ops; b_exp = ex; b_lat = lat; b_iv = 1'b1;
    forever begin
      @(negedge clk);
      if (b_ir) break;
      n++; b_waits++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL b_send_timeout: in_ready low for %0d cycles, expected accept", n);
        break;
      end
    end
    @(posedge clk); #1;
    b_iv = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 300) begin
      @(posedge clk); n++;
    end
    if (qa.size() != 0 || qb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d/%0d sets pending, expected 0", qa.size(), qb.size());
    end
    @(posedge clk); #1;
  endtask

  logic [BN*BW-1:0] ffs;
  bit               done;

  initial begin
    logic [63:0] r;
    int sent;
    ffs = '1;
    rst_n = 1'b0;
    a_iv = 1'b1; b_iv = 1'b1; a_or = 1'b1; b_or = 1'b1;
    a_ops = '1; b_ops = '1; a_exp = '0; b_exp = '0; a_lat = 0; b_lat = 0;

    // Reset with in_valid high.
    #3;
    chk("rst_a_out_valid", {31'b0, a_ov}, 32'd0);
    chk("rst_a_in_ready",  {31'b0, a_ir}, 32'd1);
    chk("rst_a_s1",        a_s1, 32'd0);
    chk("rst_a_s2",        a_s2, 32'd0);
    chk("rst_b_out_valid", {31'b0, b_ov}, 32'd0);
    chk("rst_b_in_ready",  {31'b0, b_ir}, 32'd1);
    chk("rst_b_s1_s2",     {16'b0, b_s1, b_s2}, 32'd0);
`ifdef CSA_FINAL_ADD_EN
    chk("rst_a_sum", a_sum, 32'd0);
`endif
    repeat (3) @(posedge clk);
    #1 a_iv = 1'b0; b_iv = 1'b0; rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("rst_quiet_outputs", 32'(a_tot + b_tot), 32'd0);

    // {1,2,3,4} -> 10 with latency L.
    send_a({32'd4, 32'd3, 32'd2, 32'd1}, 32'd10, 1'b1);
    send_a({32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'd5}, 32'd4, 1'b1);
    drain();

    // 7 x 8'hFF -> 8'hF9, 100 back-to-back sets at one per cycle.
    b_waits = 0; b_win = 0;
    for (int i = 0; i < 100; i++) send_b(ffs, 32'hF9, 1'b1);
    drain();
    chk("b_stream_count",   32'(b_win), 32'd100);
    chk("b_stream_span",    32'(b_last - b_first), 32'd99);
    chk("b_stream_no_wait", 32'(b_waits), 32'd0);

    // Output stall for 6 cycles while streaming into A.
    a_or = 1'b0; a_lat = 1'b0; sent = 0;
    for (int c = 0; c < 6; c++) begin
      a_ops = {32'(sent * 7), 32'(sent + 100), 32'hF000_0000, 32'(sent)};
      a_exp = msum_a(a_ops); a_iv = 1'b1;
      @(negedge clk);
      if (a_ir) sent++;
      @(posedge clk); #1;
    end
    chk("stall_sets_held",  32'(sent), 32'(LAT_A));
    chk("stall_in_ready",   {31'b0, a_ir}, 32'd0);
    chk("stall_out_valid",  {31'b0, a_ov}, 32'd1);
    a_or = 1'b1;
    a_iv = 1'b0;
    while (sent < 6) begin
      send_a({32'(sent * 7), 32'(sent + 100), 32'hF000_0000, 32'(sent)},
             32'(sent * 7 + sent + 100 + 32'hF000_0000 + sent), 1'b0);
      sent++;
    end
    drain();

    // Reset with two sets in flight on B; they must vanish.
    b_or = 1'b0;
    send_b(ffs, 32'hF9, 1'b0);
    send_b({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7}, 32'd28, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("b_preset_valid", {31'b0, b_ov}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("b_rst_out_valid", {31'b0, b_ov}, 32'd0);
    chk("b_rst_in_ready",  {31'b0, b_ir}, 32'd1);
    chk("b_rst_s1_s2",     {16'b0, b_s1, b_s2}, 32'd0);
    qb.delete();
    b_or = 1'b1; b_win = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1 chk("b_rst_discarded", 32'(b_win), 32'd0);
    send_b({8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70}, 32'd24, 1'b1);
    drain();

    // Random operands with random valid gaps and ready throttling.
    done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [AN*AW-1:0] o;
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          o = {$urandom, $urandom, $urandom, $urandom};
          send_a(o, msum_a(o), 1'b0);
        end
        done = 1;
      end
      begin
        while (!done) begin @(posedge clk); #1; a_or = ($urandom_range(0, 3) != 0); end
        a_or = 1'b1;
      end
    join
    drain();
    done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          r = {$urandom, $urandom};
          send_b(r[BN*BW-1:0], msum_b(r[BN*BW-1:0]), 1'b0);
        end
        done = 1;
      end
      begin
        while (!done) begin @(posedge clk); #1; b_or = ($urandom_range(0, 3) != 0); end
        b_or = 1'b1;
      end
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog");
  end
endmodule
